// File: rtl/dual_seq_gen.sv
// Two-channel framed serial pattern generator. Each frame is 4 payload bits,
// 4 marker bits (MARKER or zeros), then GAP_LEN idle cycles; bursts repeat the frame.
module dual_seq_gen #(
    parameter logic [3:0] MARKER  = 4'b1011,
    parameter int         GAP_LEN = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] pat1,
    input  logic [3:0] pat2,
    input  logic       mark1,
    input  logic       mark2,
    input  logic [3:0] frames,
    output logic       seq1,
    output logic       seq2,
    output logic       busy,
    output logic       frame_done,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        MARK = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [1:0] GAP_LAST = 2'(GAP_LEN - 1);

    state_t     state_q, state_d;
    logic [1:0] bit_q, bit_d;
    logic [3:0] frame_q, frame_d;
    logic [3:0] pat1_q, pat1_d;
    logic [3:0] pat2_q, pat2_d;
    logic       mark1_q, mark1_d;
    logic       mark2_q, mark2_d;
    logic       seq1_q, seq2_q, busy_q, frame_done_q, done_q;

    // Next-state, position counters and burst latches
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        pat1_d  = pat1_q;
        pat2_d  = pat2_q;
        mark1_d = mark1_q;
        mark2_d = mark2_q;
        case (state_q)
            IDLE: begin
                if (start && (frames != 4'd0)) begin
                    state_d = DATA;
                    bit_d   = 2'd0;
                    frame_d = frames;
                    pat1_d  = pat1;
                    pat2_d  = pat2;
                    mark1_d = mark1;
                    mark2_d = mark2;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (bit_q == 2'd3) begin
                    state_d = MARK;
                    bit_d   = 2'd0;
                end else begin
                    bit_d = bit_q + 2'd1;
                end
            end
            MARK: begin
                if (bit_q == 2'd3) begin
                    state_d = GAP;
                    bit_d   = 2'd0;
                end else begin
                    bit_d = bit_q + 2'd1;
                end
            end
            GAP: begin
                if (bit_q == GAP_LAST) begin
                    bit_d   = 2'd0;
                    frame_d = frame_q - 4'd1;
                    if (frame_q == 4'd1) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    bit_d = bit_q + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
                bit_d   = 2'd0;
                frame_d = 4'd0;
            end
        endcase
    end

    // State registers; outputs are registered from the upcoming state so they
    // line up with the cycle that state is active. Bit index 3-k equals ~k.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_q        <= 2'd0;
            frame_q      <= 4'd0;
            pat1_q       <= 4'd0;
            pat2_q       <= 4'd0;
            mark1_q      <= 1'b0;
            mark2_q      <= 1'b0;
            seq1_q       <= 1'b0;
            seq2_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_q        <= bit_d;
            frame_q      <= frame_d;
            pat1_q       <= pat1_d;
            pat2_q       <= pat2_d;
            mark1_q      <= mark1_d;
            mark2_q      <= mark2_d;
            busy_q       <= (state_d != IDLE);
            frame_done_q <= (state_d == GAP) && (bit_d == GAP_LAST);
            done_q       <= (state_d == GAP) && (bit_d == GAP_LAST) && (frame_d == 4'd1);
            case (state_d)
                DATA: begin
                    seq1_q <= pat1_d[~bit_d];
                    seq2_q <= pat2_d[~bit_d];
                end
                MARK: begin
                    seq1_q <= mark1_d & MARKER[~bit_d];
                    seq2_q <= mark2_d & MARKER[~bit_d];
                end
                default: begin
                    seq1_q <= 1'b0;
                    seq2_q <= 1'b0;
                end
            endcase
        end
    end

    assign seq1       = seq1_q;
    assign seq2       = seq2_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign done       = done_q;

endmodule

// File: tb/tb_dual_seq_gen.sv
// Self-checking bench for dual_seq_gen: directed vectors plus random bursts
// compared against a frame-arithmetic reference model.
module tb_dual_seq_gen;

    localparam logic [3:0] MARKER  = 4'b1011;
    localparam int         GAP_LEN = 2;
    localparam int         FLEN    = 8 + GAP_LEN;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] pat1 = 4'd0, pat2 = 4'd0, frames = 4'd0;
    logic       mark1 = 1'b0, mark2 = 1'b0;
    logic       seq1, seq2, busy, frame_done, done;

    int total = 0;
    int bad   = 0;

    dual_seq_gen #(.MARKER(MARKER), .GAP_LEN(GAP_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .pat1(pat1), .pat2(pat2), .mark1(mark1), .mark2(mark2), .frames(frames),
        .seq1(seq1), .seq2(seq2), .busy(busy), .frame_done(frame_done), .done(done)
    );

    always #5 clk = ~clk;

    // Expected {seq1,seq2,busy,frame_done,done} for burst cycle c (0-based)
    function automatic logic [4:0] model(input logic [3:0] p1, input logic [3:0] p2,
                                         input logic m1, input logic m2,
                                         input logic [3:0] fr, input int c);
        int f, k;
        logic [3:0] mk;
        logic s1, s2, fd, dn;
        mk = MARKER;
        f  = c % FLEN;
        k  = c / FLEN;
        if (f < 4) begin
            s1 = p1[3-f];
            s2 = p2[3-f];
        end else if (f < 8) begin
            s1 = m1 & mk[7-f];
            s2 = m2 & mk[7-f];
        end else begin
            s1 = 1'b0;
            s2 = 1'b0;
        end
        fd = (f == FLEN - 1);
        dn = fd && (k == int'(fr) - 1);
        return {s1, s2, 1'b1, fd, dn};
    endfunction

    task automatic run_burst(input logic [3:0] p1, input logic [3:0] p2,
                             input logic m1, input logic m2,
                             input logic [3:0] fr, input int inj, input string name);
        int n;
        logic [4:0] exp_v, act_v;
        pat1 = p1; pat2 = p2; mark1 = m1; mark2 = m2; frames = fr; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = int'(fr) * FLEN;
        for (int c = 0; c <= n; c++) begin
            exp_v = (c == n) ? 5'b00000 : model(p1, p2, m1, m2, fr, c);
            act_v = {seq1, seq2, busy, frame_done, done};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL %s cycle=%0d actual=%b required=%b", name, c + 1, act_v, exp_v);
            end
            if (c == inj) begin
                start = 1'b1; pat1 = ~p1; pat2 = ~p2; mark1 = ~m1; mark2 = ~m2; frames = 4'd2;
            end
            @(posedge clk); #1 start = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [4:0] act_v;
        #1;
        act_v = {seq1, seq2, busy, frame_done, done};
        total++;
        if (act_v !== 5'b00000) begin
            bad++;
            $display("FAIL reset_held actual=%b required=00000", act_v);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        act_v = {seq1, seq2, busy, frame_done, done};
        total++;
        if (act_v !== 5'b00000) begin
            bad++;
            $display("FAIL reset_idle actual=%b required=00000", act_v);
        end
    endtask

    task automatic test_spec_vector();
        logic [9:0] e1, e2;
        logic [4:0] exp_v, act_v;
        e1 = 10'b1010101100;
        e2 = 10'b0110101100;
        pat1 = 4'b1010; pat2 = 4'b0110; mark1 = 1'b1; mark2 = 1'b1; frames = 4'd1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 11; c++) begin
            if (c < 10) exp_v = {e1[9-c], e2[9-c], 1'b1, c == 9, c == 9};
            else        exp_v = 5'b00000;
            act_v = {seq1, seq2, busy, frame_done, done};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL spec_vector cycle=%0d actual=%b required=%b", c + 1, act_v, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_frames_zero();
        logic [4:0] act_v;
        pat1 = 4'b1111; pat2 = 4'b1111; mark1 = 1'b1; mark2 = 1'b1; frames = 4'd0; start = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            act_v = {seq1, seq2, busy, frame_done, done};
            total++;
            if (act_v !== 5'b00000) begin
                bad++;
                $display("FAIL frames_zero cycle=%0d actual=%b required=00000", c + 1, act_v);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [4:0] act_v;
        logic seen_done;
        pat1 = 4'b1100; pat2 = 4'b0011; mark1 = 1'b1; mark2 = 1'b1; frames = 4'd2; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        act_v = {seq1, seq2, busy, frame_done, done};
        total++;
        if (act_v !== 5'b00000) begin
            bad++;
            $display("FAIL mid_reset_immediate actual=%b required=00000", act_v);
        end
        seen_done = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            seen_done = seen_done | done | busy;
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (25) begin
            @(posedge clk); #1;
            seen_done = seen_done | done | busy;
        end
        total++;
        if (seen_done !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_no_done actual=%b required=0", seen_done);
        end
        run_burst(4'b1001, 4'b0101, 1'b1, 1'b0, 4'd1, -1, "after_reset");
    endtask

    task automatic test_random();
        logic [3:0] p1, p2, fr;
        logic m1, m2;
        for (int i = 0; i < 8; i++) begin
            p1 = 4'($urandom_range(0, 15));
            p2 = 4'($urandom_range(0, 15));
            m1 = 1'($urandom_range(0, 1));
            m2 = 1'($urandom_range(0, 1));
            fr = 4'($urandom_range(1, 4));
            run_burst(p1, p2, m1, m2, fr, -1, "random");
        end
        run_burst(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1, 1'b1, 4'd15, -1, "random_max_frames");
    endtask

    initial begin
        test_reset();
        test_spec_vector();
        run_burst(4'b1111, 4'b1111, 1'b1, 1'b0, 4'd1, -1, "mark_select");
        run_burst(4'b0001, 4'b1000, 1'b0, 1'b1, 4'd3, -1, "three_frames");
        run_burst(4'b1010, 4'b0110, 1'b1, 1'b1, 4'd2, 3, "start_ignored");
        test_frames_zero();
        test_mid_reset();
        test_random();
        run_burst(4'b0110, 4'b1001, 1'b1, 1'b1, 4'd1, -1, "back_to_back_a");
        run_burst(4'b1001, 4'b0110, 1'b0, 1'b1, 4'd1, -1, "back_to_back_b");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dual_seq_gen.md
DUAL_SEQ_GEN -- requirements
Module: dual_seq_gen

Interface
REQ-001 Parameter MARKER, default 4'b1011: marker pattern sent MSB first after each payload.
REQ-002 Parameter GAP_LEN, default 2: idle-zero cycles after each frame; legal range 1..3.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request to begin a burst; sampled only in IDLE.
REQ-006 pat1  input  4  channel-1 payload; latched on an accepted start.
REQ-007 pat2  input  4  channel-2 payload; latched on an accepted start.
REQ-008 mark1  input  1  1 = channel 1 sends MARKER after its payload, 0 = sends 0000; latched on an accepted start.
REQ-009 mark2  input  1  same as mark1, for channel 2.
REQ-010 frames  input  4  number of frames in the burst (1..15); latched on an accepted start.
REQ-011 seq1  output  1  channel-1 serial bit stream.
REQ-012 seq2  output  1  channel-2 serial bit stream.
REQ-013 busy  output  1  high while a burst is in progress.
REQ-014 frame_done  output  1  one-cycle pulse in the last GAP cycle of every frame.
REQ-015 done  output  1  one-cycle pulse in the last GAP cycle of the final frame.

Function
REQ-016 The FSM SHALL have four states: IDLE, DATA, MARK, GAP. A 2-bit bit counter and a 4-bit frame counter SHALL track position.
REQ-017 All outputs SHALL decode from registered state and latched data only; there SHALL be no combinational path from any input to any output.
REQ-018 In IDLE: seq1 = seq2 = 0, busy = 0, frame_done = 0, done = 0.
REQ-019 Accepted start (IDLE, start=1, frames!=0):
- latch pat1, pat2, mark1, mark2, frames;
- enter DATA with bit counter = 0.
REQ-020 start=1 with frames=0 SHALL be ignored: stay in IDLE, no pulses.
REQ-021 start while not in IDLE SHALL be ignored; latched values SHALL NOT change mid-burst.
REQ-022 DATA lasts exactly 4 cycles. In cycle k (k=0..3): seq1 = pat1_q[3-k], seq2 = pat2_q[3-k]. Then enter MARK with bit counter = 0.
REQ-023 MARK lasts exactly 4 cycles. In cycle k: seq1 = mark1_q ? MARKER[3-k] : 0; seq2 likewise with mark2_q. Then enter GAP.
REQ-024 GAP lasts exactly GAP_LEN cycles with seq1 = seq2 = 0; frame_done = 1 in its last cycle.
REQ-025 At the end of GAP:
- decrement the frame counter;
- if it was 1: done = 1 in that same cycle, then enter IDLE;
- otherwise: re-enter DATA sending the same latched payloads.
REQ-026 busy SHALL be 1 in every DATA, MARK and GAP cycle. A burst occupies exactly frames_q*(8+GAP_LEN) cycles, first DATA cycle to last GAP cycle.
REQ-027 Both channels SHALL be bit-aligned in every cycle, so a downstream pair of 1011 detectors fires in the same cycle when both marks are enabled.

Reset
REQ-028 rst_n low SHALL immediately force IDLE and clear all counters and latches; seq1, seq2, busy, frame_done and done SHALL all read 0.
REQ-029 Reset asserted mid-burst SHALL abort the burst with no done pulse; after release the block SHALL wait in IDLE for a new start.

Verification
REQ-030 pat1=1010, pat2=0110, mark1=mark2=1, frames=1, start → seq1 = 1,0,1,0,1,0,1,1,0,0; seq2 = 0,1,1,0,1,0,1,1,0,0; frame_done and done high in cycle 10; busy 10 cycles.
REQ-031 pat1=pat2=1111, mark1=1, mark2=0, frames=1 → MARK cycles: seq1 = 1011, seq2 = 0000.
REQ-032 frames=3, pat1=0001 → seq1 repeats the 10-bit frame 3 times; frame_done pulses at cycles 10, 20, 30; done only at cycle 30; busy drops at cycle 31.
REQ-033 Second start with different patterns at cycle 4 of a burst → ignored; output matches the first patterns exactly.
REQ-034 frames=0 with start → busy stays 0, seq1 = seq2 = 0, no pulses.
REQ-035 rst_n low in cycle 6 of a burst → all outputs 0 immediately, no done; a new start after release produces a complete correct frame.
